// File: rtl/demux_rr_sched.sv
// ----------------------------------------------------------------------------
// demux_rr_sched
//
// Purpose:
//   Round-robin 1-to-4 demultiplexer for a single-bit valid/ready stream.
//   One incoming bit is held at a time and offered to one destination lane,
//   selected by a rotating pointer. Each delivery advances the pointer to the
//   next lane (3 wraps to 0). While a bit is being delivered, a new bit can be
//   accepted on the same cycle, so the stream runs at one bit per cycle when
//   the selected destination is ready.
//
// Optional feature (macro DEMUX_SKIP_EN):
//   When defined, a destination that leaves the held bit undelivered for
//   MAX_WAIT consecutive cycles is skipped. The pointer moves to the next lane,
//   the held bit is kept and offered there, and 'skip' pulses for one cycle.
//   When undefined, the block waits on the selected lane indefinitely and
//   'skip' is tied low.
//
// Parameters:
//   MAX_WAIT   stalled cycles on one lane before a skip (1..15)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   source presents a data bit
//   in_data    source data bit
//   in_ready   block accepts in_data this cycle
//   out_ready  per-destination ready, bit i belongs to lane i
//   out_valid  per-destination valid, at most one bit high
//   out_data   per-destination data bit, zero on non-selected lanes
//   sel        currently selected destination index
//   skip       one-cycle pulse when a lane is skipped on timeout
// ----------------------------------------------------------------------------
module demux_rr_sched #(
    parameter int MAX_WAIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_data,
    output logic       in_ready,
    input  logic [3:0] out_ready,
    output logic [3:0] out_valid,
    output logic [3:0] out_data,
    output logic [1:0] sel,
    output logic       skip
);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_range
        $error("demux_rr_sched: MAX_WAIT must be in the range 1..15");
    end

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] sel_q,   sel_d;
    logic       hold_q,  hold_d;

    logic       sel_ready;

    // Only the currently selected lane's ready matters; the others are
    // deliberately ignored.
    assign sel_ready = out_ready[sel_q];

`ifdef DEMUX_SKIP_EN
    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    logic [3:0] wait_q, wait_d;
    logic       skip_q, skip_d;
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            hold_q  <= 1'b0;
`ifdef DEMUX_SKIP_EN
            wait_q  <= 4'd0;
            skip_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
`ifdef DEMUX_SKIP_EN
            wait_q  <= wait_d;
            skip_q  <= skip_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
`ifdef DEMUX_SKIP_EN
        wait_d  = wait_q;
        skip_d  = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                // Accepting into an empty holder does not move the pointer.
                if (in_valid) begin
                    hold_d  = in_data;
                    state_d = HOLD;
                end
`ifdef DEMUX_SKIP_EN
                wait_d = 4'd0;
`endif
            end

            HOLD: begin
                if (sel_ready) begin
                    // Delivery: rotate to the next lane. A bit arriving on
                    // the same edge refills the holder so no bubble appears.
                    sel_d = sel_q + 2'd1;
                    if (in_valid) begin
                        hold_d = in_data;
                    end else begin
                        state_d = IDLE;
                    end
`ifdef DEMUX_SKIP_EN
                    wait_d = 4'd0;
`endif
                end else begin
`ifdef DEMUX_SKIP_EN
                    // Stalled lane: after MAX_WAIT stalled cycles, offer the
                    // same held bit to the next lane instead.
                    if (wait_q == WAIT_LAST) begin
                        sel_d  = sel_q + 2'd1;
                        wait_d = 4'd0;
                        skip_d = 1'b1;
                    end else begin
                        wait_d = wait_q + 4'd1;
                    end
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from the registered state so that an asynchronous
    // reset clears them immediately.
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = 4'b0000;
        if (state_q == HOLD) begin
            out_valid[sel_q] = 1'b1;
        end
    end

    assign out_data = out_valid & {4{hold_q}};
    assign in_ready = (state_q == IDLE) || sel_ready;
    assign sel      = sel_q;

`ifdef DEMUX_SKIP_EN
    assign skip = skip_q;
`else
    assign skip = 1'b0;
`endif

endmodule

// File: tb/tb_demux_rr_sched.sv
module tb_demux_rr_sched;

    localparam int MAX_WAIT = 8;
`ifdef DEMUX_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_data;
    logic       in_ready;
    logic [3:0] out_ready;
    logic [3:0] out_valid;
    logic [3:0] out_data;
    logic [1:0] sel;
    logic       skip;

    int vectors;
    int miscompares;

    demux_rr_sched #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .skip      (skip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural reference: a holder that is either empty or carries one
    // bit, a lane pointer, and a count of stalled cycles on that lane.
    // ------------------------------------------------------------------
    bit m_has;
    bit m_bit;
    int m_sel;
    int m_stall;
    bit m_skip;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_has   <= 1'b0;
            m_bit   <= 1'b0;
            m_sel   <= 0;
            m_stall <= 0;
            m_skip  <= 1'b0;
        end else begin
            m_skip <= 1'b0;
            if (!m_has) begin
                if (in_valid) begin
                    m_has <= 1'b1;
                    m_bit <= in_data;
                end
            end else if (out_ready[m_sel]) begin
                m_sel   <= (m_sel + 1) % 4;
                m_stall <= 0;
                if (in_valid) m_bit <= in_data;
                else          m_has <= 1'b0;
            end else if (SKIP_EN && (m_stall + 1 == MAX_WAIT)) begin
                m_sel   <= (m_sel + 1) % 4;
                m_stall <= 0;
                m_skip  <= 1'b1;
            end else begin
                m_stall <= m_stall + 1;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        logic [3:0] e_valid;
        logic [3:0] e_data;
        logic       e_ready;
        e_valid = m_has ? (4'b0001 << m_sel) : 4'b0000;
        e_data  = m_bit ? e_valid : 4'b0000;
        e_ready = !m_has || out_ready[m_sel];
        vectors = vectors + 1;
        if (out_valid !== e_valid || out_data !== e_data || in_ready !== e_ready ||
            sel !== 2'(m_sel) || skip !== m_skip) begin
            miscompares = miscompares + 1;
            $display("FAIL model t=%0t: got valid=%b data=%b ready=%b sel=%0d skip=%b, expected valid=%b data=%b ready=%b sel=%0d skip=%b",
                     $time, out_valid, out_data, in_ready, sel, skip,
                     e_valid, e_data, e_ready, m_sel, m_skip);
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s t=%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = 1'b0;
        out_ready   = 4'b0000;
        tick();
        tick();

        // Reset state
        #1;
        chk("rst_valid", out_valid, 4'b0000);
        chk("rst_data",  out_data,  4'b0000);
        chk("rst_sel",   {2'b00, sel}, 4'd0);
        chk("rst_ready", {3'b000, in_ready}, 4'd1);
        chk("rst_skip",  {3'b000, skip}, 4'd0);
        rst = 1'b0;

        // Back-to-back bits 1,0,1,1 to all-ready lanes
        tick();
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_data   = 1'b1;
        tick();
        in_data = 1'b0;
        #1;
        chk("b2b_v0", out_valid, 4'b0001);
        chk("b2b_d0", out_data,  4'b0001);
        tick();
        in_data = 1'b1;
        #1;
        chk("b2b_v1", out_valid, 4'b0010);
        chk("b2b_d1", out_data,  4'b0000);
        chk("b2b_s1", {2'b00, sel}, 4'd1);
        tick();
        in_data = 1'b1;
        #1;
        chk("b2b_v2", out_valid, 4'b0100);
        chk("b2b_d2", out_data,  4'b0100);
        tick();
        in_valid = 1'b0;
        #1;
        chk("b2b_v3", out_valid, 4'b1000);
        chk("b2b_d3", out_data,  4'b1000);
        chk("b2b_s3", {2'b00, sel}, 4'd3);
        tick();
        #1;
        chk("b2b_idle", out_valid, 4'b0000);
        chk("b2b_wrap", {2'b00, sel}, 4'd0);

        // Stall lane 0 for three cycles, then release
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_v", out_valid, 4'b0001);
            chk("stall_rdy", {3'b000, in_ready}, 4'd0);
            tick();
        end
        out_ready = 4'b0001;
        #1;
        chk("stall_rel_rdy", {3'b000, in_ready}, 4'd1);
        tick();
        #1;
        chk("stall_done_v", out_valid, 4'b0000);
        chk("stall_done_s", {2'b00, sel}, 4'd1);

        // Lane 0 never ready, others ready
        do_reset();
        out_ready = 4'b1110;
        in_valid  = 1'b1;
        in_data   = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < MAX_WAIT; i++) begin
            #1;
            chk("to_wait_v", out_valid, 4'b0001);
            chk("to_wait_k", {3'b000, skip}, 4'd0);
            tick();
        end
`ifdef DEMUX_SKIP_EN
        #1;
        chk("to_skip_k", {3'b000, skip}, 4'd1);
        chk("to_skip_s", {2'b00, sel}, 4'd1);
        chk("to_skip_d", out_data, 4'b0010);
        tick();
        #1;
        chk("to_after_k", {3'b000, skip}, 4'd0);
        chk("to_after_v", out_valid, 4'b0000);
        chk("to_after_s", {2'b00, sel}, 4'd2);
`else
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_hold_v", out_valid, 4'b0001);
            chk("to_hold_s", {2'b00, sel}, 4'd0);
            chk("to_hold_k", {3'b000, skip}, 4'd0);
            tick();
        end
`endif

        // Asynchronous reset while holding a 1 on lane 2
        do_reset();
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_data   = 1'b0;
        tick();
        tick();
        in_data = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        #1;
        chk("ar_pre_v", out_data, 4'b0100);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_v",   out_valid, 4'b0000);
        chk("ar_d",   out_data,  4'b0000);
        chk("ar_s",   {2'b00, sel}, 4'd0);
        chk("ar_rdy", {3'b000, in_ready}, 4'd1);
        tick();
        rst = 1'b0;

        // in_data toggling without in_valid
        out_ready = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            in_data = i[0];
            tick();
            #1;
            chk("nv_v", out_valid, 4'b0000);
            chk("nv_s", {2'b00, sel}, 4'd0);
        end

        // Randomized traffic, alternating bursts of free and sparse readiness
        begin
            bit sparse;
            bit rst_pending;
            sparse      = 1'b0;
            rst_pending = 1'b0;
            for (int c = 0; c < 4000; c++) begin
                tick();
                if (rst_pending) begin
                    rst         = 1'b0;
                    rst_pending = 1'b0;
                end
                if (c % 64 == 0) sparse = $urandom_range(0, 1) == 1;
                in_valid  = $urandom_range(0, 3) != 0;
                in_data   = $urandom_range(0, 1) == 1;
                out_ready = sparse ? 4'($urandom & $urandom & $urandom) : 4'($urandom);
                if ($urandom_range(0, 299) == 0) begin
                    #2;
                    rst         = 1'b1;
                    rst_pending = 1'b1;
                end
            end
        end
        tick();
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
